// File: rtl/fizzbuzz_fmt_if.sv
// Request and byte-stream signals between the BCD counter, fizzbuzz_fmt and uart_tx.
// master drives requests and uart busy; slave is the formatter.
interface fizzbuzz_fmt_if #(
    parameter int DIGITS = 2
);
    logic [DIGITS*4-1:0] i_num_bcd;
    logic                i_num_valid;
    logic                o_busy;
    logic                i_tx_busy;
    logic [7:0]          o_tx_data;
    logic                o_tx_valid;
    logic                o_msg_done;
    logic                o_err;

    modport master (
        output i_num_bcd,
        output i_num_valid,
        output i_tx_busy,
        input  o_busy,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_msg_done,
        input  o_err
    );

    modport slave (
        input  i_num_bcd,
        input  i_num_valid,
        input  i_tx_busy,
        output o_busy,
        output o_tx_data,
        output o_tx_valid,
        output o_msg_done,
        output o_err
    );
endinterface

// File: rtl/fizzbuzz_fmt.sv
// FizzBuzz message formatter: classifies one BCD number per request and streams
// "Fizz"/"Buzz"/"FizzBuzz" or its decimal digits plus a line terminator into uart_tx.
module fizzbuzz_fmt #(
    parameter int DIGITS  = 2,
    parameter bit CRLF    = 1'b1,
    parameter int HOLDOFF = 1
) (
    input  logic          clk,
    input  logic          rst,
    fizzbuzz_fmt_if.slave bus
);
    localparam int NUM_W   = DIGITS * 4;
    localparam int SUM_W   = $clog2(9 * DIGITS + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_LEN = ((DIGITS > 8) ? DIGITS : 8) + 2;
    localparam int PTR_W   = $clog2(MAX_LEN + 1);

    localparam logic [PTR_W-1:0] TERM_LEN = CRLF ? PTR_W'(2) : PTR_W'(1);

    localparam logic [7:0] FIZZBUZZ_STR [8] = '{8'h46, 8'h69, 8'h7A, 8'h7A,
                                                8'h42, 8'h75, 8'h7A, 8'h7A};
    localparam logic [7:0] FIZZ_STR [4] = '{8'h46, 8'h69, 8'h7A, 8'h7A};
    localparam logic [7:0] BUZZ_STR [4] = '{8'h42, 8'h75, 8'h7A, 8'h7A};

    typedef enum logic [1:0] {
        IDLE,
        CLASSIFY,
        SEND,
        HOLD
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [NUM_W-1:0] r_num;
    logic             r_div3;
    logic             r_div5;
    logic [IDX_W-1:0] r_msbIdx;
    logic [PTR_W-1:0] r_bytePtr;
    logic [2:0]       r_holdCnt;
    logic             r_err;

    logic             w_badNibble;
    logic             w_accept;
    logic [SUM_W-1:0] w_digitSum;
    logic             w_div3;
    logic             w_div5;
    logic [IDX_W-1:0] w_msbIdx;
    logic [3:0]       w_digits [DIGITS];
    logic [IDX_W-1:0] w_digitSel;
    logic [PTR_W-1:0] w_bodyLen;
    logic [PTR_W-1:0] w_msgLen;
    logic [7:0]       w_byte;
    logic             w_strobe;

    always_comb begin
        w_badNibble = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.i_num_bcd[d*4 +: 4] > 4'd9) begin
                w_badNibble = 1'b1;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && bus.i_num_valid && !w_badNibble;

    // Digit sum never exceeds 9*DIGITS, so its mod-3 is exact for any supported width.
    always_comb begin
        w_digits   = '{default: 4'd0};
        w_digitSum = '0;
        w_msbIdx   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            w_digits[d] = r_num[d*4 +: 4];
            w_digitSum  = w_digitSum + SUM_W'(r_num[d*4 +: 4]);
            if (r_num[d*4 +: 4] != 4'd0) begin
                w_msbIdx = IDX_W'(d);
            end
        end
    end

    assign w_div3 = ((w_digitSum % SUM_W'(3)) == '0);
    assign w_div5 = (r_num[3:0] == 4'd0) || (r_num[3:0] == 4'd5);

    always_comb begin
        w_bodyLen  = '0;
        w_byte     = 8'h00;
        w_digitSel = r_msbIdx - IDX_W'(r_bytePtr);
        case ({r_div3, r_div5})
            2'b11:        w_bodyLen = PTR_W'(8);
            2'b10, 2'b01: w_bodyLen = PTR_W'(4);
            default:      w_bodyLen = PTR_W'(r_msbIdx) + PTR_W'(1);
        endcase
        if (r_bytePtr < w_bodyLen) begin
            case ({r_div3, r_div5})
                2'b11:   w_byte = FIZZBUZZ_STR[r_bytePtr[2:0]];
                2'b10:   w_byte = FIZZ_STR[r_bytePtr[1:0]];
                2'b01:   w_byte = BUZZ_STR[r_bytePtr[1:0]];
                default: w_byte = 8'h30 + {4'h0, w_digits[w_digitSel]};
            endcase
        end else if (CRLF && (r_bytePtr == w_bodyLen)) begin
            w_byte = 8'h0D;
        end else begin
            w_byte = 8'h0A;
        end
    end

    assign w_msgLen = w_bodyLen + TERM_LEN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_strobe    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = CLASSIFY;
                end
            end
            CLASSIFY: begin
                w_nextState = SEND;
            end
            SEND: begin
                if (!bus.i_tx_busy) begin
                    w_strobe    = 1'b1;
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (r_holdCnt == 3'd0) begin
                    w_nextState = (r_bytePtr == w_msgLen) ? IDLE : SEND;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The byte pointer already points past the strobed byte while in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num     <= '0;
            r_div3    <= 1'b0;
            r_div5    <= 1'b0;
            r_msbIdx  <= '0;
            r_bytePtr <= '0;
            r_holdCnt <= 3'd0;
            r_err     <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && bus.i_num_valid && w_badNibble;
            if (w_accept) begin
                r_num <= bus.i_num_bcd;
            end
            if (r_state == CLASSIFY) begin
                r_div3    <= w_div3;
                r_div5    <= w_div5;
                r_msbIdx  <= w_msbIdx;
                r_bytePtr <= '0;
            end
            if (w_strobe) begin
                r_bytePtr <= r_bytePtr + PTR_W'(1);
                r_holdCnt <= 3'(HOLDOFF - 1);
            end else if ((r_state == HOLD) && (r_holdCnt != 3'd0)) begin
                r_holdCnt <= r_holdCnt - 3'd1;
            end
        end
    end

    assign bus.o_tx_valid = w_strobe;
    assign bus.o_tx_data  = w_strobe ? w_byte : 8'h00;
    assign bus.o_msg_done = w_strobe && (r_bytePtr == (w_msgLen - PTR_W'(1)));
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_err      = r_err;

endmodule

// File: doc/fizzbuzz_fmt.md
Name: fizzbuzz_fmt

Overview:
Message formatter between the BCD command counter and uart_tx. It accepts one BCD number per request and classifies it as divisible by 3, 5, both, or neither. It then streams the ASCII message byte-by-byte into uart_tx using that block's valid/busy handshake: "Fizz", "Buzz", "FizzBuzz" or the decimal digits, followed by a line terminator. This replaces the raw digit echo with true FizzBuzz output.

Parameters:
DIGITS, 2, number of BCD digits in i_num_bcd (width DIGITS*4)
CRLF, 1, 1: terminator is 0x0D 0x0A; 0: terminator is 0x0A only
HOLDOFF, 1, cycles after each issued byte during which i_tx_busy is ignored (covers uart_tx busy-assert latency); range 1..7

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
i_num_bcd  input  DIGITS*4  number to format, BCD, digit 0 in bits [3:0]
i_num_valid  input  1  single-cycle request; sampled only when o_busy=0
o_busy  output  1  high from the cycle after an accepted request until the cycle after the last byte is issued
i_tx_busy  input  1  uart_tx busy
o_tx_data  output  8  byte to uart_tx, valid only with o_tx_valid
o_tx_valid  output  1  single-cycle byte strobe to uart_tx
o_msg_done  output  1  single-cycle pulse coincident with the terminator's final byte strobe
o_err  output  1  single-cycle pulse, request rejected because of a non-BCD nibble

Behaviour:
- Reset values: o_busy=0, o_tx_valid=0, o_tx_data=0, o_msg_done=0, o_err=0. State=IDLE. Holdoff counter=0.
- States: IDLE, CLASSIFY, SEND, HOLD.
- IDLE: on i_num_valid=1, register i_num_bcd and go to CLASSIFY. If any nibble is >9, pulse o_err next cycle, stay IDLE, and emit nothing.
- i_num_valid while o_busy=1 is ignored and dropped, with no queueing.
- CLASSIFY (1 cycle), registered results:
  - div3 = (sum of all digits) mod 3 == 0
  - div5 = digit0 is 0 or 5
  - msb_idx = index of the highest nonzero digit, or 0 if the value is 0
  - Then go to SEND.
- Message selection:
  - div3&div5: "FizzBuzz"
  - div3 only: "Fizz"
  - div5 only: "Buzz"
  - else: digits from msb_idx down to 0, each "0"+digit; leading zeros suppressed.
  - Then the terminator.
  - Value 0 is divisible by 15 and outputs "FizzBuzz".
- SEND: when i_tx_busy=0, drive o_tx_valid=1 with the current byte for exactly one cycle, advance the byte pointer, and go to HOLD.
  - When i_tx_busy=1, hold in SEND with o_tx_valid=0. There is no timeout.
- HOLD: wait HOLDOFF cycles ignoring i_tx_busy.
  - Then return to SEND if bytes remain, otherwise go to IDLE.
- o_busy deasserts on entry to IDLE after the last byte. A new request is accepted in the first IDLE cycle.
- Latency: request accepted at cycle N gives the first o_tx_valid at N+2 minimum, when i_tx_busy=0. Byte spacing is at least HOLDOFF+1 cycles.
- o_msg_done is asserted in the same cycle as the final terminator byte strobe.
- Message length:
  - FizzBuzz: 8+T bytes
  - Fizz or Buzz: 4+T bytes
  - number: (msb_idx+1)+T bytes
  - T is 2 if CRLF=1, else 1.
  - The byte pointer must cover max(8, DIGITS)+2.
- Reset mid-message: abandons the message. o_tx_valid is 0 the next cycle and the state is IDLE. No partial terminator is sent.
- Simultaneous rst and i_num_valid: rst wins.
- The digit-sum adder is sized for 9*DIGITS. The mod-3 result must be correct for all DIGITS up to 8.

Test Plan:
1. Request 0x15, i_tx_busy=0 -> bytes 46 69 7A 7A 42 75 7A 7A 0D 0A, each strobe 2 cycles apart; o_msg_done with 0A; first strobe 2 cycles after the request.
2. Requests 0x09, then 0x10, then 0x07 -> "Fizz\r\n", "Buzz\r\n", "7\r\n" (37 0D 0A; leading zero suppressed).
3. Request 0x98 and 0x00 -> "98\r\n" (39 38 0D 0A); 0x00 -> "FizzBuzz\r\n".
4. Back-pressure: request 0x03, hold i_tx_busy=1 for 20 cycles after the first strobe -> no further strobes until busy drops, then resume with the 'i' byte (0x69); no byte lost or repeated.
5. Request while busy: second i_num_valid with 0x05 during an 0x03 message -> ignored, only "Fizz\r\n" emitted. Request 0x1A -> o_err pulse, no strobes, o_busy stays 0.
6. Assert rst after the 3rd byte of "FizzBuzz" -> o_tx_valid=0 from the next cycle, o_busy=0. A new request 0x05 -> "Buzz\r\n" cleanly.
